// File: rtl/uart_cmd_parser_if.sv
// Bundles the parser's UART-side and control-bus-side signals.
// The parser takes the master modport; the UART/camera side takes the slave modport.
interface uart_cmd_parser_if;
    logic [11:0] rx_count;
    logic [7:0]  rx_data;
    logic [15:0] bus_id;
    logic [15:0] bus_din;
    logic        bus_write;
    logic [15:0] reg_id;
    logic [15:0] reg_data;
    logic        reg_write;
    logic        busy;
    logic [7:0]  nak_count;

    modport master (
        input  rx_count, rx_data,
        output bus_id, bus_din, bus_write, reg_id, reg_data, reg_write, busy, nak_count
    );

    modport slave (
        output rx_count, rx_data,
        input  bus_id, bus_din, bus_write, reg_id, reg_data, reg_write, busy, nak_count
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Pops UART rx bytes, assembles AA/ID/DATA/CHK packets, drives control-bus writes
// and queues ACK/NAK replies. Optional inter-byte timeout: define CMD_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_parser_if.master cmd
);
    localparam logic [15:0] ID_RSP_STORE = 16'h0201;
    localparam logic [15:0] ID_RSP_FLUSH = 16'h0202;
    localparam logic [15:0] ID_POP       = 16'h0204;

    typedef enum logic [2:0] {
        IDLE, POP, SETTLE, DISPATCH, EXEC, RSP_STORE, RSP_FLUSH
    } state_t;

    state_t      state, state_next;
    logic [7:0]  byte_reg;
    logic [7:0]  chk;
    logic [7:0]  rsp;
    logic [7:0]  rsp_value;
    logic [2:0]  index;
    logic [1:0]  settle_cnt;
    logic [31:0] payload;
    logic [15:0] reg_id_q;
    logic [15:0] reg_data_q;
    logic [7:0]  nak_cnt;
    logic        load_rsp;
    logic        reg_write;
    logic        timeout_hit;
    logic [15:0] bus_id;
    logic [15:0] bus_din;
    logic        bus_write;

    always_comb begin
        state_next = state;
        bus_id     = 16'h0000;
        bus_din    = 16'h0000;
        bus_write  = 1'b0;
        reg_write  = 1'b0;
        load_rsp   = 1'b0;
        rsp_value  = ACK_BYTE;
        case (state)
            IDLE: begin
                if (cmd.rx_count != 12'd0) state_next = POP;
            end
            POP: begin
                bus_id     = ID_POP;
                bus_write  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 2'd2) state_next = DISPATCH;
            end
            DISPATCH: begin
                state_next = IDLE;
                if (index == 3'd5) begin
                    if (byte_reg == chk) begin
                        state_next = EXEC;
                    end else begin
                        state_next = RSP_STORE;
                        load_rsp   = 1'b1;
                        rsp_value  = NAK_BYTE;
                    end
                end
            end
            EXEC: begin
                // Ids 0x02xx belong to the UART itself and are never forwarded
                load_rsp   = 1'b1;
                state_next = RSP_STORE;
                if (payload[31:24] == 8'h02) begin
                    rsp_value = NAK_BYTE;
                end else begin
                    reg_write = 1'b1;
                    rsp_value = ACK_BYTE;
                end
            end
            RSP_STORE: begin
                bus_id     = ID_RSP_STORE;
                bus_din    = {8'h00, rsp};
                bus_write  = 1'b1;
                state_next = RSP_FLUSH;
            end
            RSP_FLUSH: begin
                bus_id     = ID_RSP_FLUSH;
                bus_write  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_reg   <= 8'h00;
            chk        <= 8'h00;
            rsp        <= 8'h00;
            index      <= 3'd0;
            settle_cnt <= 2'd0;
            payload    <= 32'h0;
            reg_id_q   <= 16'h0000;
            reg_data_q <= 16'h0000;
            nak_cnt    <= 8'h00;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 2'd1 : 2'd0;
            if (state == IDLE && cmd.rx_count != 12'd0) byte_reg <= cmd.rx_data;
            if (load_rsp) rsp <= rsp_value;
            if (reg_write) begin
                reg_id_q   <= payload[31:16];
                reg_data_q <= payload[15:0];
            end
            if (state == RSP_STORE && rsp == NAK_BYTE && nak_cnt != 8'hFF)
                nak_cnt <= nak_cnt + 8'd1;
            if (state == DISPATCH) begin
                case (index)
                    3'd0: if (byte_reg == SYNC_BYTE) index <= 3'd1;
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        payload <= {payload[23:0], byte_reg};
                        chk     <= chk ^ byte_reg;
                        index   <= index + 3'd1;
                    end
                    default: begin
                        index <= 3'd0;
                        chk   <= 8'h00;
                    end
                endcase
            end else if (timeout_hit) begin
                index <= 3'd0;
                chk   <= 8'h00;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Stalled partial packets are dropped silently once the line has been quiet too long
    logic [23:0] idle_timer;
    assign timeout_hit = (state == IDLE) && (index != 3'd0) && (idle_timer == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset)
            idle_timer <= 24'd0;
        else if (state == DISPATCH || timeout_hit)
            idle_timer <= 24'd0;
        else if (state == IDLE && index != 3'd0)
            idle_timer <= idle_timer + 24'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The strobe presents the new id/data immediately; the held copy covers idle cycles
    assign cmd.bus_id    = bus_id;
    assign cmd.bus_din   = bus_din;
    assign cmd.bus_write = bus_write;
    assign cmd.reg_write = reg_write;
    assign cmd.reg_id    = reg_write ? payload[31:16] : reg_id_q;
    assign cmd.reg_data  = reg_write ? payload[15:0]  : reg_data_q;
    assign cmd.busy      = (state != IDLE);
    assign cmd.nak_count = nak_cnt;
endmodule
